// File: rtl/slot_mux32_pkg.sv
// slot_mux32_pkg: shared types and helpers for the 32-slot time-multiplexer.
//   slot_t    - {op, ch} slot number, same packing as wr_addr
//   state_e   - commit FSM states
//   pos0_f    - position offset for a given pipeline stage
//   slot_map  - position (0..31) -> {op, ch}, same ordering as the separator
package slot_mux32_pkg;

  localparam int unsigned SLOTS  = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned CH_W   = 3;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [CH_W-1:0] ch;
  } slot_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  // Offset between the global counter and the position seen at stage stg.
  function automatic logic [ADDR_W-1:0] pos0_f(input logic [ADDR_W-1:0] stg);
    return ADDR_W'(6'd33 - 6'(stg));
  endfunction

  // Positions 0-7 slot1, 8-15 slot3, 16-23 slot2, 24-31 slot4; ch in the low bits.
  function automatic slot_t slot_map(input logic [ADDR_W-1:0] pos);
    slot_t s;
    s.ch = pos[CH_W-1:0];
    case (pos[ADDR_W-1:CH_W])
      2'd0:    s.op = 2'd0;
      2'd1:    s.op = 2'd2;
      2'd2:    s.op = 2'd1;
      default: s.op = 2'd3;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/slot_mux32_if.sv
// slot_mux32_if: write/commit/output bundle of slot_mux32.
//   wr_en/wr_addr/wr_data/wr_ready - shadow bank write port
//   commit/commit_done             - shadow -> active request and completion pulse
//   mixed/frame_start              - time-multiplexed output and position-0 marker
interface slot_mux32_if
  import slot_mux32_pkg::*;
#(
  parameter int unsigned width = 10
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [width-1:0]  wr_data;
  logic              wr_ready;
  logic              commit;
  logic              commit_done;
  logic [width-1:0]  mixed;
  logic              frame_start;

  modport master (
    output wr_en, wr_addr, wr_data, commit,
    input  wr_ready, commit_done, mixed, frame_start
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, commit,
    output wr_ready, commit_done, mixed, frame_start
  );

endinterface

// File: rtl/slot_mux32_bank.sv
// slot_mux32_bank: shadow and active register banks, 32 x width each.
//   clk, rst_n        - clock, async active-low reset (both banks clear)
//   wr_en/addr/data   - shadow write port
//   copy              - bulk shadow -> active copy on this edge
//   rd_addr/rd_data_c - async read of the bank that is active after this edge
module slot_mux32_bank
  import slot_mux32_pkg::*;
#(
  parameter int unsigned width = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [width-1:0]  wr_data,
  input  logic              copy,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [width-1:0]  rd_data_c
);

  logic [SLOTS-1:0][width-1:0] shadow_q, shadow_d;
  logic [SLOTS-1:0][width-1:0] active_q, active_d;

  // Write port and atomic copy.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (wr_en) shadow_d[wr_addr] = wr_data;
    if (copy)  active_d = shadow_q;
  end

  // On the copy edge the reader already needs the new bank, so forward shadow.
  assign rd_data_c = copy ? shadow_q[rd_addr] : active_q[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/slot_mux32.sv
// slot_mux32: drives one stored value per channel/operator slot onto a
// time-multiplexed bus aligned to the slot counter at pipeline stage stg.
// Values are written into a shadow bank and copied to the active bank at
// the next frame boundary after a commit.
//   clk, rst_n - clock, async active-low reset
//   cnt        - global slot counter (wraps 31 -> 0)
//   bus        - slot_mux32_if.slave: write port, commit handshake, mixed output
//   mask       - per-slot output enable, only with SLOT_MUX_MASK_EN defined
// Build option: SLOT_MUX_MASK_EN adds the mask input.
module slot_mux32
  import slot_mux32_pkg::*;
#(
  parameter int unsigned      width = 10,
  parameter logic [ADDR_W-1:0] stg  = 5'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cnt,
  slot_mux32_if.slave       bus
`ifdef SLOT_MUX_MASK_EN
  ,
  input  logic [SLOTS-1:0]  mask
`endif
);

  localparam logic [ADDR_W-1:0] POS0 = pos0_f(stg);

  state_e            state_q, state_d;
  logic              wr_ready_q, wr_ready_d;
  logic              commit_done_q, commit_done_d;
  logic              frame_start_q, frame_start_d;
  logic [width-1:0]  mixed_q, mixed_d;

  logic [ADDR_W-1:0] nxt_c;
  logic              frame_edge_c;
  logic              copy_c;
  logic              wr_accept_c;
  slot_t             slot_c;
  logic [ADDR_W-1:0] rd_addr_c;
  logic [width-1:0]  rd_data_c;

  // Position loaded into the output register on this edge (+1 for that register).
  assign nxt_c        = cnt + POS0 + ADDR_W'(1);
  assign frame_edge_c = (nxt_c == '0);
  assign slot_c       = slot_map(nxt_c);
  assign rd_addr_c    = slot_c;
  assign wr_accept_c  = bus.wr_en & wr_ready_q;

  slot_mux32_bank #(
    .width (width)
  ) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_accept_c),
    .wr_addr   (bus.wr_addr),
    .wr_data   (bus.wr_data),
    .copy      (copy_c),
    .rd_addr   (rd_addr_c),
    .rd_data_c (rd_data_c)
  );

  // Commit FSM: a commit waits for the next frame boundary, never the current edge.
  always_comb begin
    state_d       = state_q;
    copy_c        = 1'b0;
    commit_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.commit) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (frame_edge_c) begin
          copy_c        = 1'b1;
          commit_done_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    wr_ready_d = (state_d == ST_IDLE);
  end

  // Output path.
  always_comb begin
    mixed_d = rd_data_c;
`ifdef SLOT_MUX_MASK_EN
    if (!mask[rd_addr_c]) mixed_d = '0;
`endif
    frame_start_d = frame_edge_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      wr_ready_q    <= 1'b1;
      commit_done_q <= 1'b0;
      frame_start_q <= 1'b0;
      mixed_q       <= '0;
    end else begin
      state_q       <= state_d;
      wr_ready_q    <= wr_ready_d;
      commit_done_q <= commit_done_d;
      frame_start_q <= frame_start_d;
      mixed_q       <= mixed_d;
    end
  end

  assign bus.wr_ready    = wr_ready_q;
  assign bus.commit_done = commit_done_q;
  assign bus.frame_start = frame_start_q;
  assign bus.mixed       = mixed_q;

endmodule
